// File: rtl/seg7_readback.sv
// Readback checker: debounces an active-low 7-segment bus and decodes it back to a digit code.
// Optional SEG7_ERRCNT_EN adds a saturating err_count of illegal commits.
module seg7_readback #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       sample_en,
    output logic [4:0] value_out,
    output logic       new_pulse,
    output logic       locked,
    output logic       illegal,
    output logic       blank
`ifdef SEG7_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {StIdle, StSettling, StLocked} state_e;

    localparam logic [6:0] SegOff = 7'b1111111;

    state_e           state_q, state_d;
    logic [6:0]       last_seg_q, last_seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       value_q, value_d;
    logic             pulse_q, pulse_d;
    logic             illegal_q, illegal_d;
    logic             blank_q, blank_d;
    logic             commit;
    logic [5:0]       dec;

    // Returns {hit, code}; hit=0 for patterns outside the table.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'b0000001: r = {1'b1, 5'd0};
            7'b1001111: r = {1'b1, 5'd1};
            7'b0010010: r = {1'b1, 5'd2};
            7'b0000110: r = {1'b1, 5'd3};
            7'b1001100: r = {1'b1, 5'd4};
            7'b0100100: r = {1'b1, 5'd5};
            7'b0100000: r = {1'b1, 5'd6};
            7'b0001111: r = {1'b1, 5'd7};
            7'b0000000: r = {1'b1, 5'd8};
            7'b0000100: r = {1'b1, 5'd9};
            7'b0001000: r = {1'b1, 5'd10};
            7'b1100000: r = {1'b1, 5'd11};
            7'b0110001: r = {1'b1, 5'd12};
            7'b1000010: r = {1'b1, 5'd13};
            7'b0110000: r = {1'b1, 5'd14};
            7'b0111000: r = {1'b1, 5'd15};
            7'b0100001: r = {1'b1, 5'd16};
            default:    r = 6'd0;
        endcase
        return r;
    endfunction

`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        last_seg_d = last_seg_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        illegal_d  = illegal_q;
        blank_d    = blank_q;
        pulse_d    = 1'b0;
        commit     = 1'b0;
`ifdef SEG7_ERRCNT_EN
        err_d      = err_q;
`endif
        if (sample_en) begin
            if (state_q == StIdle || seg_in != last_seg_q) begin
                last_seg_d = seg_in;
                cnt_d      = CNT_W'(1);
                state_d    = StSettling;
                commit     = (cnt_d == CNT_W'(STABLE_CYCLES));
            end else if (state_q == StSettling) begin
                cnt_d  = cnt_q + CNT_W'(1);
                commit = (cnt_d == CNT_W'(STABLE_CYCLES));
            end
        end

        dec = decode(last_seg_d);
        if (commit) begin
            state_d = StLocked;
            pulse_d = 1'b1;
            if (dec[5]) begin
                value_d   = dec[4:0];
                illegal_d = 1'b0;
                blank_d   = 1'b0;
            end else if (last_seg_d == SegOff) begin
                value_d   = 5'd0;
                illegal_d = 1'b0;
                blank_d   = 1'b1;
            end else begin
                // Illegal pattern keeps the previous code so downstream sees the last good digit.
                illegal_d = 1'b1;
                blank_d   = 1'b0;
`ifdef SEG7_ERRCNT_EN
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_seg_q <= SegOff;
            cnt_q      <= '0;
            value_q    <= 5'd0;
            pulse_q    <= 1'b0;
            illegal_q  <= 1'b0;
            blank_q    <= 1'b1;
`ifdef SEG7_ERRCNT_EN
            err_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_seg_q <= last_seg_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            pulse_q    <= pulse_d;
            illegal_q  <= illegal_d;
            blank_q    <= blank_d;
`ifdef SEG7_ERRCNT_EN
            err_q      <= err_d;
`endif
        end
    end

    assign value_out = value_q;
    assign new_pulse = pulse_q;
    assign locked    = (state_q == StLocked);
    assign illegal   = illegal_q;
    assign blank     = blank_q;
`ifdef SEG7_ERRCNT_EN
    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_seg7_readback.sv
// Randomized bench for seg7_readback against a run-length reference model.
module tb_seg7_readback;

    localparam int unsigned StableCycles = 4;
    localparam logic [6:0] PatTbl [17] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b0100001};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'h7F;
    logic       sample_en = 1'b0;
    logic [4:0] value_out;
    logic       new_pulse, locked, illegal, blank;
`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: length of the current run of identical enabled samples.
    int         m_run;
    logic [6:0] m_prev;
    int         m_val, m_err;
    logic       m_pulse, m_ill, m_blank;

    seg7_readback #(.STABLE_CYCLES(StableCycles), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .sample_en (sample_en),
        .value_out (value_out),
        .new_pulse (new_pulse),
        .locked    (locked),
        .illegal   (illegal),
        .blank     (blank)
`ifdef SEG7_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 17; i++) if (PatTbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_update(input logic [6:0] s, input logic en, input logic r);
        int code;
        if (r) begin
            m_run = 0; m_val = 0; m_err = 0;
            m_pulse = 0; m_ill = 0; m_blank = 1;
            return;
        end
        m_pulse = 0;
        if (!en) return;
        if (m_run == 0 || s != m_prev) m_run = 1;
        else m_run++;
        m_prev = s;
        if (m_run == StableCycles) begin
            m_pulse = 1;
            code = lookup(s);
            if (code >= 0) begin
                m_val = code; m_ill = 0; m_blank = 0;
            end else if (s == 7'h7F) begin
                m_val = 0; m_ill = 0; m_blank = 1;
            end else begin
                m_ill = 1; m_blank = 0;
                if (m_err < 255) m_err++;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("value_out", 32'(value_out), 32'(m_val));
        check_eq("new_pulse", 32'(new_pulse), 32'(m_pulse));
        check_eq("locked", 32'(locked), 32'(m_run >= StableCycles));
        check_eq("illegal", 32'(illegal), 32'(m_ill));
        check_eq("blank", 32'(blank), 32'(m_blank));
`ifdef SEG7_ERRCNT_EN
        check_eq("err_count", 32'(err_count), 32'(m_err));
`endif
    endtask

    task automatic step(input logic [6:0] s, input logic en, input logic r);
        @(negedge clk);
        seg_in = s; sample_en = en; rst = r;
        @(posedge clk);
        model_update(s, en, r);
        #1;
        compare_all();
    endtask

    task automatic repeat_step(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b1, 1'b0);
    endtask

    initial begin
        logic [6:0] cur;
        int k;

        // Reset state
        step(7'h7F, 1'b0, 1'b1);
        check_eq("rst_value", 32'(value_out), 0);
        check_eq("rst_blank", 32'(blank), 1);

        // Basic commit of 3, then hold without re-commit
        repeat_step(7'b0000110, 4);
        check_eq("t1_value", 32'(value_out), 3);
        check_eq("t1_pulse", 32'(new_pulse), 1);
        repeat_step(7'b0000110, 10);
        check_eq("t1_nopulse", 32'(new_pulse), 0);

        // Glitch breaks stability
        step(7'h7F, 1'b0, 1'b1);
        repeat_step(7'b0000110, 3);
        repeat_step(7'b0010010, 1);
        repeat_step(7'b0000110, 3);
        check_eq("t2_noearly", 32'(new_pulse), 0);
        repeat_step(7'b0000110, 1);
        check_eq("t2_value", 32'(value_out), 3);

        // Disabled samples neither break nor advance stability
        step(7'h7F, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(7'b0100001, (i % 2) == 0, 1'b0);
        check_eq("t3_value", 32'(value_out), 16);

        // Illegal commit after a legal one
        repeat_step(7'b0000110, 4);
        repeat_step(7'b1111110, 4);
        check_eq("t4_illegal", 32'(illegal), 1);
        check_eq("t4_value", 32'(value_out), 3);

        // Blank commit
        repeat_step(7'b0000001, 4);
        repeat_step(7'h7F, 4);
        check_eq("t5_blank", 32'(blank), 1);
        check_eq("t5_value", 32'(value_out), 0);

        // Reset mid-settle, then full settle needed
        repeat_step(7'b0001000, 2);
        step(7'b0001000, 1'b1, 1'b1);
        repeat_step(7'b0001000, 3);
        check_eq("t6_noearly", 32'(new_pulse), 0);
        repeat_step(7'b0001000, 1);
        check_eq("t6_value", 32'(value_out), 10);

        // Error counter saturation
        step(7'h7F, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) repeat_step((i % 2) ? 7'b1111101 : 7'b1111110, 4);
`ifdef SEG7_ERRCNT_EN
        check_eq("t7_errsat", 32'(err_count), 255);
`endif
        check_eq("t7_illegal", 32'(illegal), 1);

        // Randomized traffic
        step(7'h7F, 1'b0, 1'b1);
        cur = PatTbl[0];
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 25) begin
                k = $urandom_range(19);
                if (k < 17) cur = PatTbl[k];
                else if (k == 17) cur = 7'h7F;
                else cur = 7'($urandom);
            end
            step(cur, $urandom_range(3) != 0, $urandom_range(199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
